axis_frame_fifo: RTL

Store-and-forward AXI-Stream frame FIFO placed directly downstream of the block-RAM stream reader. It accepts beats on the slave stream, holds each frame until its `tlast` beat has been written, and only then releases the whole frame on the master stream. The slave side never back-pressures after reset. A frame that does not fit is dropped in full, so the consumer only ever sees complete frames.

---
 rtl/axis_frame_fifo.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: store-and-forward AXI-Stream frame FIFO.
// A frame becomes visible to the reader only once its tlast beat is stored;
// frames that do not fit are dropped whole. Slave side never back-pressures.
// Optional statistics outputs (frame_count, drop_count) are enabled by
// defining AXIS_FRAME_FIFO_STATS_EN; otherwise both outputs read as zero.
module axis_frame_fifo #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_DEPTH     = 512,
    parameter int G_PTRWIDTH  = $clog2(G_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [G_DATAWIDTH-1:0] s_axi_tdata,
    input  logic                   s_axi_tvalid,
    input  logic                   s_axi_tlast,
    output logic                   s_axi_tready,
    output logic [G_DATAWIDTH-1:0] m_axi_tdata,
    output logic                   m_axi_tvalid,
    output logic                   m_axi_tlast,
    input  logic                   m_axi_tready,
    output logic [G_PTRWIDTH-1:0]  frame_count,
    output logic [15:0]            drop_count
);

    localparam int                    LP_AW    = G_PTRWIDTH - 1;
    localparam logic [G_PTRWIDTH-1:0] LP_DEPTH = G_PTRWIDTH'(G_DEPTH);

    typedef enum logic {
        ST_ACCEPT,
        ST_DROP
    } state_t;

    // storage: {tlast, tdata}
    logic [G_DATAWIDTH:0]   r_mem [G_DEPTH];

    logic [G_PTRWIDTH-1:0]  r_wr_ptr;
    logic [G_PTRWIDTH-1:0]  r_commit_ptr;
    logic [G_PTRWIDTH-1:0]  r_rd_ptr;
    state_t                 r_state;

    logic                   r_m_valid;
    logic                   r_m_last;
    logic [G_DATAWIDTH-1:0] r_m_data;

    logic [G_PTRWIDTH-1:0]  w_used;
    logic                   w_s_hs;
    logic                   w_full;
    logic                   w_wr_en;
    logic                   w_out_hs;
    logic                   w_load;

    assign s_axi_tready = ~rst;
    assign w_s_hs       = s_axi_tvalid & s_axi_tready;

    // occupancy against the registered read pointer: a same-cycle read
    // does not free space for this cycle's write
    assign w_used   = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_used == LP_DEPTH);
    assign w_wr_en  = (r_state == ST_ACCEPT) & w_s_hs & ~w_full;

    assign w_out_hs = r_m_valid & m_axi_tready;
    assign w_load   = (r_rd_ptr != r_commit_ptr) & (~r_m_valid | w_out_hs);

    assign m_axi_tvalid = r_m_valid;
    assign m_axi_tlast  = r_m_last;
    assign m_axi_tdata  = r_m_data;

    // write-side FSM: store beats, commit on tlast, rewind and drop on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ACCEPT;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (w_s_hs) begin
                        if (w_full) begin
                            r_wr_ptr <= r_commit_ptr;
                            if (!s_axi_tlast) begin
                                r_state <= ST_DROP;
                            end
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (s_axi_tlast) begin
                                r_commit_ptr <= r_wr_ptr + 1'b1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (w_s_hs && s_axi_tlast) begin
                        r_state <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

    // storage write port
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[LP_AW-1:0]] <= {s_axi_tlast, s_axi_tdata};
        end
    end

    // output register: refill from committed storage when empty or draining
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else if (w_load) begin
            r_rd_ptr              <= r_rd_ptr + 1'b1;
            r_m_valid             <= 1'b1;
            {r_m_last, r_m_data}  <= r_mem[r_rd_ptr[LP_AW-1:0]];
        end else if (w_out_hs) begin
            r_m_valid <= 1'b0;
        end
    end

`ifdef AXIS_FRAME_FIFO_STATS_EN
    logic [G_PTRWIDTH-1:0] r_frame_cnt;
    logic [15:0]           r_drop_cnt;
    logic                  w_commit;
    logic                  w_out_last_hs;
    logic                  w_drop_evt;

    assign w_commit      = w_wr_en & s_axi_tlast;
    assign w_out_last_hs = w_out_hs & r_m_last;
    assign w_drop_evt    = w_s_hs & s_axi_tlast &
                           (((r_state == ST_ACCEPT) & w_full) | (r_state == ST_DROP));

    // committed frames not yet fully emitted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else begin
            case ({w_commit, w_out_last_hs})
                2'b10:   r_frame_cnt <= r_frame_cnt + 1'b1;
                2'b01:   r_frame_cnt <= r_frame_cnt - 1'b1;
                default: r_frame_cnt <= r_frame_cnt;
            endcase
        end
    end

    // saturating count of dropped frames
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign frame_count = r_frame_cnt;
    assign drop_count  = r_drop_cnt;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule
